// File: rtl/booth_pkg.sv
// Shared types and helpers for the iterative radix-2 Booth multiplier.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_NOP,
        OP_ADD,
        OP_SUB
    } booth_op_t;

    // The iteration counter must hold WIDTH+1.
    function automatic int unsigned count_w(input int unsigned width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of M into A, then an
// arithmetic right shift of {A,Q,Q_1}.
module booth_step
    import booth_pkg::*;
#(
    parameter int unsigned W1 = 5
) (
    input  logic [W1-1:0] a,
    input  logic [W1-1:0] q,
    input  logic          q_1,
    input  logic [W1-1:0] m,
    output logic [W1-1:0] a_next,
    output logic [W1-1:0] q_next,
    output logic          q_1_next
);

    booth_op_t     op;
    logic [W1-1:0] sum;

    always_comb begin
        case ({q[0], q_1})
            2'b01:   op = OP_ADD;
            2'b10:   op = OP_SUB;
            default: op = OP_NOP;
        endcase

        case (op)
            OP_ADD:  sum = a + m;
            OP_SUB:  sum = a - m;
            default: sum = a;
        endcase

        a_next   = {sum[W1-1], sum[W1-1:1]};
        q_next   = {sum[0], q[W1-1:1]};
        q_1_next = q[0];
    end

endmodule

// File: rtl/booth_seq_multiplier.sv
// Iterative radix-2 Booth multiplier with start/busy/done handshake and
// per-operation signed/unsigned selection.
module booth_seq_multiplier
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned    W1         = WIDTH + 1;
    localparam int unsigned    CW         = count_w(WIDTH);
    localparam logic [CW-1:0]  COUNT_INIT = CW'(W1);

    state_t        state;
    state_t        state_next;
    logic [W1-1:0] a;
    logic [W1-1:0] q;
    logic [W1-1:0] m;
    logic          q_1;
    logic [W1-1:0] a_next;
    logic [W1-1:0] q_next;
    logic          q_1_next;
    logic [CW-1:0] count;
    logic          accept;
    logic          last;

    assign accept = start && (state != RUN);
    assign last   = (state == RUN) && (count == CW'(1));

    booth_step #(.W1(W1)) u_step (
        .a        (a),
        .q        (q),
        .q_1      (q_1),
        .m        (m),
        .a_next   (a_next),
        .q_next   (q_next),
        .q_1_next (q_1_next)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = DONE;
            DONE:    if (start) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // One extra guard bit lets unsigned operands run through the signed core.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a       <= '0;
            q       <= '0;
            q_1     <= 1'b0;
            m       <= '0;
            count   <= '0;
            product <= '0;
        end else if (accept) begin
            m     <= {signed_mode & multiplicand[WIDTH-1], multiplicand};
            q     <= {signed_mode & multiplier[WIDTH-1], multiplier};
            a     <= '0;
            q_1   <= 1'b0;
            count <= COUNT_INIT;
        end else if (state == RUN) begin
            a     <= a_next;
            q     <= q_next;
            q_1   <= q_1_next;
            count <= count - CW'(1);
            // Low 2*WIDTH bits of the shifted {A,Q}.
            if (last) begin
                product <= {a_next[WIDTH-2:0], q_next};
            end
        end
    end

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Directed and randomised checks of booth_seq_multiplier at WIDTH 4, 8 and 16.
module tb_booth_seq_multiplier;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        signed_mode;
    logic        start4;
    logic        start_w;
    logic [3:0]  mcand4, mplier4;
    logic        busy4, done4;
    logic [7:0]  prod4;
    logic [7:0]  mcand8, mplier8;
    logic        busy8, done8;
    logic [15:0] prod8;
    logic [15:0] mcand16, mplier16;
    logic        busy16, done16;
    logic [31:0] prod16;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    booth_seq_multiplier #(.WIDTH(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .start(start4), .signed_mode(signed_mode),
        .multiplicand(mcand4), .multiplier(mplier4),
        .busy(busy4), .done(done4), .product(prod4)
    );

    booth_seq_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(start_w), .signed_mode(signed_mode),
        .multiplicand(mcand8), .multiplier(mplier8),
        .busy(busy8), .done(done8), .product(prod8)
    );

    booth_seq_multiplier #(.WIDTH(16)) dut16 (
        .clk(clk), .reset_n(reset_n), .start(start_w), .signed_mode(signed_mode),
        .multiplicand(mcand16), .multiplier(mplier16),
        .busy(busy16), .done(done16), .product(prod16)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ref_mul(input int unsigned w, input logic sm,
                                            input logic [31:0] x, input logic [31:0] y);
        longint xs, ys, p;
        xs = longint'(x & ((32'd1 << w) - 32'd1));
        ys = longint'(y & ((32'd1 << w) - 32'd1));
        if (sm && x[w-1]) xs = xs - (longint'(1) << w);
        if (sm && y[w-1]) ys = ys - (longint'(1) << w);
        p = xs * ys;
        return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    task automatic mul4(input string tag, input logic sm, input logic [3:0] x,
                        input logic [3:0] y, input logic [7:0] exp);
        int unsigned lat;
        int unsigned busy_cyc;
        signed_mode = sm;
        mcand4      = x;
        mplier4     = y;
        start4      = 1'b1;
        step();
        start4   = 1'b0;
        lat      = 0;
        busy_cyc = 0;
        while (!done4 && lat < 20) begin
            if (busy4) busy_cyc++;
            step();
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd5);
        check({tag, "_busy"}, 64'(busy_cyc), 64'd5);
        check({tag, "_product"}, 64'(prod4), 64'(exp));
    endtask

    initial begin
        int unsigned lat;
        logic        sm_r;

        reset_n     = 1'b0;
        start4      = 1'b0;
        start_w     = 1'b0;
        signed_mode = 1'b0;
        mcand4      = '0;
        mplier4     = '0;
        mcand8      = '0;
        mplier8     = '0;
        mcand16     = '0;
        mplier16    = '0;
        #23;
        check("reset_busy", 64'(busy4), 64'd0);
        check("reset_done", 64'(done4), 64'd0);
        check("reset_product", 64'(prod4), 64'd0);
        reset_n = 1'b1;
        step();

        mul4("s_m8xm8", 1'b1, 4'h8, 4'h8, 8'h40);
        mul4("s_7xm3", 1'b1, 4'h7, 4'hD, 8'hEB);
        mul4("u_15x15", 1'b0, 4'hF, 4'hF, 8'hE1);
        mul4("s_m1xm1", 1'b1, 4'hF, 4'hF, 8'h01);
        mul4("u_8x8", 1'b0, 4'h8, 4'h8, 8'h40);
        mul4("u_15x0", 1'b0, 4'hF, 4'h0, 8'h00);
        mul4("s_m1xm1_b", 1'b1, 4'hF, 4'hF, 8'h01);

        // start pulsed mid-run with other operands must be ignored
        signed_mode = 1'b1;
        mcand4      = 4'h7;
        mplier4     = 4'hD;
        start4      = 1'b1;
        step();
        start4 = 1'b0;
        step();
        step();
        start4      = 1'b1;
        signed_mode = 1'b0;
        mcand4      = 4'h1;
        mplier4     = 4'h1;
        step();
        start4 = 1'b0;
        check("ignore_busy", 64'(busy4), 64'd1);
        check("ignore_hold_product", 64'(prod4), 64'h01);
        lat = 3;
        while (!done4 && lat < 20) begin
            step();
            lat++;
        end
        check("ignore_latency", 64'(lat), 64'd5);
        check("ignore_product", 64'(prod4), 64'hEB);

        // held start: back-to-back 15*15 then 3*5 unsigned
        signed_mode = 1'b0;
        mcand4      = 4'hF;
        mplier4     = 4'hF;
        start4      = 1'b1;
        step();
        check("b2b_done_low", 64'(done4), 64'd0);
        mcand4  = 4'h3;
        mplier4 = 4'h5;
        repeat (5) step();
        check("b2b_first_done", 64'(done4), 64'd1);
        check("b2b_first_product", 64'(prod4), 64'hE1);
        step();
        start4 = 1'b0;
        check("b2b_restart_done", 64'(done4), 64'd0);
        check("b2b_restart_busy", 64'(busy4), 64'd1);
        check("b2b_restart_product", 64'(prod4), 64'hE1);
        repeat (5) step();
        check("b2b_second_done", 64'(done4), 64'd1);
        check("b2b_second_product", 64'(prod4), 64'h0F);

        // reset during iteration 3
        signed_mode = 1'b1;
        mcand4      = 4'h7;
        mplier4     = 4'hD;
        start4      = 1'b1;
        step();
        start4 = 1'b0;
        step();
        step();
        reset_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy4), 64'd0);
        check("midrst_done", 64'(done4), 64'd0);
        check("midrst_product", 64'(prod4), 64'd0);
        #4;
        reset_n = 1'b1;
        step();
        check("postrst_idle_busy", 64'(busy4), 64'd0);
        check("postrst_idle_done", 64'(done4), 64'd0);
        mul4("postrst_s_7xm3", 1'b1, 4'h7, 4'hD, 8'hEB);

        for (int i = 0; i < 12; i++) begin
            sm_r        = (i % 2) == 0;
            signed_mode = sm_r;
            mcand8      = (i < 2) ? 8'h80 : 8'($urandom);
            mplier8     = (i < 2) ? 8'h80 : 8'($urandom);
            mcand16     = (i < 2) ? 16'hFFFF : 16'($urandom);
            mplier16    = (i < 2) ? 16'h8000 : 16'($urandom);
            start_w     = 1'b1;
            step();
            start_w = 1'b0;
            lat     = 0;
            while (!(done8 && done16) && lat < 40) begin
                step();
                lat++;
            end
            check("rand_latency", 64'(lat), 64'd17);
            check("rand_w8", 64'(prod8), ref_mul(8, sm_r, 32'(mcand8), 32'(mplier8)));
            check("rand_w16", 64'(prod16), ref_mul(16, sm_r, 32'(mcand16), 32'(mplier16)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
